mul_div_unit: RTL and testbench

Iterative MUL AB / DIV AB execution unit placed directly upstream of the PSW register. It latches A and B on a start pulse and computes one bit per cycle: shift-add for MUL, restoring division for DIV. On completion it presents the A/B results to the register-file/SFR write path. In the same cycle it presents carry/overflow and a CY_OV flag-set request to the PSW.

---
 rtl/mul_div_unit_pkg.sv | 26 ++
 rtl/mul_div_datapath.sv | 95 +++++++++
 rtl/mul_div_unit.sv | 131 +++++++++++++
 tb/tb_mul_div_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared encodings for the MUL AB / DIV AB unit
//
// Purpose: PSW flag-set request encodings (also used by the PSW and the ALU),
// operation select encoding and the mul_div_unit FSM state type.
// Ports: none (package).

package mul_div_unit_pkg;

  localparam logic [1:0] NO_SET       = 2'b00;
  localparam logic [1:0] CY_SET       = 2'b01;
  localparam logic [1:0] CY_OV_SET    = 2'b10;
  localparam logic [1:0] CY_OV_AC_SET = 2'b11;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_div_datapath.sv
// rtl/mul_div_datapath.sv - shift-add multiply / restoring divide datapath
//
// Purpose: holds the 2*WIDTH working register ({hi, lo}), the latched B
// operand and the registered results. One step per cycle of either
// shift-add multiplication or restoring division.
// Ports:
//   clock, reset             clock, asynchronous active-high reset
//   load                     latch acc_in into lo, b_in into operand, clear hi
//   acc_in, b_in             A and B operands (used only with load / div_zero)
//   mul_step, div_step       perform one multiply / divide iteration
//   capture                  store the result of the current (final) step
//   div_zero                 store the divide-by-zero result
//   acc_out, b_out           registered results (low/quotient, high/remainder)
//   overflow_out             registered overflow result

module mul_div_datapath
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mul_step,
  input  logic             div_step,
  input  logic             capture,
  input  logic             div_zero,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] b_out,
  output logic             overflow_out
);

  // For MUL: hi = partial product, lo = multiplier (A) shifting out.
  // For DIV: hi = remainder, lo = dividend shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_n;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  assign hi = work[2*WIDTH-1:WIDTH];
  assign lo = work[WIDTH-1:0];

  always_comb begin
    sum    = {1'b0, hi} + ({1'b0, operand} & {(WIDTH+1){lo[0]}});
    // The remainder stays below the divisor, so the shifted value fits in
    // WIDTH+1 bits; a set MSB of trial means the subtraction went negative.
    rem_sh = {hi, lo[WIDTH-1]};
    trial  = rem_sh - {1'b0, operand};
    work_n = work;
    if (mul_step) begin
      // Carry of the add enters the MSB as the whole register shifts right.
      work_n = {sum, lo[WIDTH-1:1]};
    end else if (div_step) begin
      if (!trial[WIDTH]) begin
        work_n = {trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      end else begin
        work_n = {rem_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work         <= '0;
      operand      <= '0;
      acc_out      <= '0;
      b_out        <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (load) begin
        work    <= {{WIDTH{1'b0}}, acc_in};
        operand <= b_in;
      end else if (mul_step || div_step) begin
        work <= work_n;
      end

      if (capture) begin
        acc_out      <= work_n[WIDTH-1:0];
        b_out        <= work_n[2*WIDTH-1:WIDTH];
        overflow_out <= mul_step ? (|work_n[2*WIDTH-1:WIDTH]) : 1'b0;
      end else if (div_zero) begin
        acc_out      <= '1;
        b_out        <= acc_in;
        overflow_out <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MUL AB / DIV AB unit feeding the PSW
//
// Purpose: FSM and iteration counter around mul_div_datapath. One bit per
// cycle; presents results plus a CY_OV flag-set request for one done cycle.
// Ports:
//   clock, reset             clock, asynchronous active-high reset
//   start, op                request (accepted in IDLE only); 0=MUL, 1=DIV
//   acc_in, b_in             A and B operands, sampled with start
//   busy                     high while iterating (MUL/DIV states)
//   done                     one-cycle result-valid pulse
//   acc_out, b_out           MUL low/high byte, DIV quotient/remainder
//   carry_out                always 0
//   overflow_out             MUL product > 0xFF, DIV divisor == 0
//   flag_set                 CY_OV_SET during done, else NO_SET

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] b_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic [1:0]       flag_set
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] counter;
  logic             load;
  logic             mul_step;
  logic             div_step;
  logic             capture;
  logic             div_zero;
  logic             last_iter;

  assign last_iter = (counter == CNT_W'(WIDTH-1));
  assign carry_out = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        counter <= '0;
      end else if (mul_step || div_step) begin
        counter <= counter + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    mul_step   = 1'b0;
    div_step   = 1'b0;
    capture    = 1'b0;
    div_zero   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    flag_set   = NO_SET;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (op == OP_MUL) begin
            next_state = ST_MUL;
          end else if (b_in == '0) begin
            // Divide by zero skips iteration and reports on the next cycle.
            div_zero   = 1'b1;
            next_state = ST_DONE;
          end else begin
            next_state = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        busy     = 1'b1;
        mul_step = 1'b1;
        if (last_iter) begin
          capture    = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DIV: begin
        busy     = 1'b1;
        div_step = 1'b1;
        if (last_iter) begin
          capture    = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        flag_set   = CY_OV_SET;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  mul_div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .acc_in      (acc_in),
    .b_in        (b_in),
    .mul_step    (mul_step),
    .div_step    (div_step),
    .capture     (capture),
    .div_zero    (div_zero),
    .acc_out     (acc_out),
    .b_out       (b_out),
    .overflow_out(overflow_out)
  );

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit

module tb_mul_div_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       op;
  logic [7:0] acc_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] acc_out;
  logic [7:0] b_out;
  logic       carry_out;
  logic       overflow_out;
  logic [1:0] flag_set;

  int compared   = 0;
  int mismatched = 0;

  mul_div_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .acc_in      (acc_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .acc_out     (acc_out),
    .b_out       (b_out),
    .carry_out   (carry_out),
    .overflow_out(overflow_out),
    .flag_set    (flag_set)
  );

  always #5 clock = ~clock;

  // Reference: {overflow, b result, acc result} from plain arithmetic.
  function automatic logic [16:0] ref_model(input logic o, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    if (!o) begin
      p = a * b;
      return {(p > 16'd255), p[15:8], p[7:0]};
    end else if (b == 8'd0) begin
      return {1'b1, a, 8'hFF};
    end else begin
      return {1'b0, 8'(a % b), 8'(a / b)};
    end
  endfunction

  // Issues one request and waits (bounded) for done; returns what was seen.
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [16:0] res, output logic cy,
                        output logic [1:0] fs, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    res      = '0;
    cy       = 1'b0;
    fs       = 2'b00;
    @(negedge clock);
    start  = 1'b1;
    op     = o;
    acc_in = a;
    b_in   = b;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i == 1) begin
        start  = 1'b0;
        acc_in = 8'($urandom);
        b_in   = 8'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        res = {overflow_out, b_out, acc_out};
        cy  = carry_out;
        fs  = flag_set;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    acc_in = 8'h00;
    b_in   = 8'h00;
    #12;
    compared++;
    if ({busy, done, acc_out, b_out, carry_out, overflow_out, flag_set} !== 22'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got busy=%b done=%b acc=%h b=%h cy=%b ov=%b fs=%b, expected all zero",
               busy, done, acc_out, b_out, carry_out, overflow_out, flag_set);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_op(input string name, input logic o, input logic [7:0] a, input logic [7:0] b);
    int          lat;
    int          busy_cnt;
    logic [16:0] res;
    logic [16:0] exp_res;
    logic        cy;
    logic [1:0]  fs;
    int          exp_lat;
    exp_res = ref_model(o, a, b);
    exp_lat = (o && b == 8'd0) ? 1 : 9;
    run_op(o, a, b, lat, res, cy, fs, busy_cnt);
    compared++;
    if (lat !== exp_lat) begin
      mismatched++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    compared++;
    if (res !== exp_res || cy !== 1'b0 || fs !== 2'b10) begin
      mismatched++;
      $display("FAIL %s result: got ov=%b b=%h acc=%h cy=%b fs=%b expected ov=%b b=%h acc=%h cy=0 fs=10",
               name, res[16], res[15:8], res[7:0], cy, fs, exp_res[16], exp_res[15:8], exp_res[7:0]);
    end
    compared++;
    if (busy_cnt !== exp_lat - 1) begin
      mismatched++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_lat - 1);
    end
    @(negedge clock);
    compared++;
    if (done !== 1'b0 || flag_set !== 2'b00 || {overflow_out, b_out, acc_out} !== exp_res) begin
      mismatched++;
      $display("FAIL %s hold: got done=%b fs=%b ov=%b b=%h acc=%h expected done=0 fs=00 results held",
               name, done, flag_set, overflow_out, b_out, acc_out);
    end
  endtask

  task automatic test_directed();
    check_op("mul_50_a0", 1'b0, 8'h50, 8'hA0);
    check_op("mul_0f_0f", 1'b0, 8'h0F, 8'h0F);
    check_op("mul_ff_ff", 1'b0, 8'hFF, 8'hFF);
    check_op("mul_zero_a", 1'b0, 8'h00, 8'h9C);
    check_op("mul_zero_b", 1'b0, 8'hC3, 8'h00);
    check_op("div_fb_12", 1'b1, 8'hFB, 8'h12);
    check_op("div_07_09", 1'b1, 8'h07, 8'h09);
    check_op("div_ff_01", 1'b1, 8'hFF, 8'h01);
    check_op("div_by_zero", 1'b1, 8'h42, 8'h00);
  endtask

  task automatic test_random();
    logic       o;
    logic [7:0] a;
    logic [7:0] b;
    for (int n = 0; n < 40; n++) begin
      o = 1'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      check_op(o ? "rand_div" : "rand_mul", o, a, b);
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    @(negedge clock);
    start  = 1'b1;
    op     = 1'b0;
    acc_in = 8'h02;
    b_in   = 8'h03;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (i == 3) begin
        start  = 1'b1;
        op     = 1'b1;
        acc_in = 8'hF0;
        b_in   = 8'h05;
      end
      if (done) begin
        done_cnt++;
        compared++;
        if (acc_out !== 8'h06 || b_out !== 8'h00 || i !== 9) begin
          mismatched++;
          $display("FAIL ignored_start_result: got acc=%h b=%h at cycle %0d expected acc=06 b=00 at cycle 9",
                   acc_out, b_out, i);
        end
      end
    end
    compared++;
    if (done_cnt !== 1 || acc_out !== 8'h06 || b_out !== 8'h00 || overflow_out !== 1'b0) begin
      mismatched++;
      $display("FAIL ignored_start_single_done: got %0d done pulses acc=%h b=%h ov=%b expected 1 pulse acc=06 b=00 ov=0",
               done_cnt, acc_out, b_out, overflow_out);
    end
  endtask

  task automatic test_reset_midway();
    int          done_cnt = 0;
    int          lat;
    int          busy_cnt;
    logic [16:0] res;
    logic        cy;
    logic [1:0]  fs;
    @(negedge clock);
    start  = 1'b1;
    op     = 1'b0;
    acc_in = 8'hFF;
    b_in   = 8'hFF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({busy, done, acc_out, b_out, carry_out, overflow_out, flag_set} !== 22'd0) begin
      mismatched++;
      $display("FAIL reset_midway_outputs: got busy=%b done=%b acc=%h b=%h ov=%b fs=%b expected all zero",
               busy, done, acc_out, b_out, overflow_out, flag_set);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done || busy) done_cnt++;
    end
    compared++;
    if (done_cnt !== 0) begin
      mismatched++;
      $display("FAIL reset_midway_abandon: got %0d busy/done cycles expected 0", done_cnt);
    end
    run_op(1'b0, 8'h0D, 8'h0B, lat, res, cy, fs, busy_cnt);
    compared++;
    if (lat !== 9 || res !== ref_model(1'b0, 8'h0D, 8'h0B)) begin
      mismatched++;
      $display("FAIL reset_midway_restart: got lat=%0d ov=%b b=%h acc=%h expected lat=9 ov=0 b=00 acc=8f",
               lat, res[16], res[15:8], res[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
